// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin issue of NUM_REQ requesters onto one pipelined divider,
// with a tag pipeline that routes each quotient back to the requester that issued it.
module fp_div_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PRECISION = 32,
   parameter int DIV_LATENCY = 5,
   parameter int MAX_OUTSTANDING = 3,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   input  logic [NUM_REQ*PRECISION-1:0] i_req_a,
   input  logic [NUM_REQ*PRECISION-1:0] i_req_b,
   output logic [PRECISION-1:0]         o_div_a_operand,
   output logic [PRECISION-1:0]         o_div_b_operand,
   output logic                         o_div_reset_n,
   input  logic [PRECISION-1:0]         i_div_result,
   output logic [NUM_REQ-1:0]           o_rsp_valid,
   output logic [PRECISION-1:0]         o_rsp_data,
   output logic [IW-1:0]                o_rsp_id,
   output logic                         o_idle
);
   logic [IW-1:0]                  r_ptr;
   logic [NUM_REQ-1:0][2:0]        r_cnt;
   logic [DIV_LATENCY-1:0]         r_tag_v;
   logic [DIV_LATENCY-1:0][IW-1:0] r_tag_id;
   logic [NUM_REQ-1:0]             w_elig;
   logic                           w_gnt_any;
   logic [IW-1:0]                  w_gnt_id;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign w_elig[i] = ~i_reset & i_req_valid[i] & (r_cnt[i] < 3'(MAX_OUTSTANDING));
   end
   // Scan downward so the last hit is the first eligible requester at or above r_ptr.
   always_comb begin
      logic [IW:0] idx;
      w_gnt_any = 1'b0;
      w_gnt_id = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, r_ptr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
         if (w_elig[idx[IW-1:0]]) begin
            w_gnt_any = 1'b1;
            w_gnt_id = idx[IW-1:0];
         end
      end
   end
   assign o_req_ready = w_gnt_any ? NUM_REQ'(1) << w_gnt_id : '0;
   assign o_div_a_operand = w_gnt_any ? i_req_a[w_gnt_id*PRECISION +: PRECISION] : '0;
   assign o_div_b_operand = w_gnt_any ? i_req_b[w_gnt_id*PRECISION +: PRECISION] : '0;
   assign o_div_reset_n = ~i_reset;
   assign o_idle = ~|r_tag_v & ~|o_rsp_valid & ~|r_cnt;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ptr <= '0;
         r_cnt <= '0;
         r_tag_v <= '0;
         r_tag_id <= '0;
         o_rsp_valid <= '0;
         o_rsp_data <= '0;
         o_rsp_id <= '0;
      end else begin
         if (w_gnt_any) r_ptr <= (w_gnt_id == IW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
         r_tag_v[0] <= w_gnt_any;
         r_tag_id[0] <= w_gnt_id;
         for (int s = 1; s < DIV_LATENCY; s++) begin
            r_tag_v[s] <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
         end
         o_rsp_valid <= r_tag_v[DIV_LATENCY-1] ? NUM_REQ'(1) << r_tag_id[DIV_LATENCY-1] : '0;
         if (r_tag_v[DIV_LATENCY-1]) begin
            o_rsp_data <= i_div_result;
            o_rsp_id <= r_tag_id[DIV_LATENCY-1];
         end
         // Credit returns while the response is on the output, so a full requester waits one extra cycle.
         for (int i = 0; i < NUM_REQ; i++)
            r_cnt[i] <= r_cnt[i] + 3'(o_req_ready[i]) - 3'(o_rsp_valid[i]);
      end
   end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed steps for fp_div_arbiter with a stand-in divider pipeline
// and a response scoreboard filled at every observed issue.
module tb_fp_div_arbiter;
   localparam int N = 4, P = 32, L = 5;
   logic clk = 1'b0, reset = 1'b1;
   logic [N-1:0] req_valid, req_ready, rsp_valid;
   logic [N*P-1:0] req_a, req_b;
   logic [P-1:0] div_a, div_b, div_result, rsp_data;
   logic div_reset_n, idle;
   logic [1:0] rsp_id;
   logic [P-1:0] pipe [L];
   int cyc = 0, total = 0, passed = 0, errs = 0, mg;
   typedef struct {logic [1:0] id; logic [P-1:0] data; int at;} exp_t;
   exp_t q[$];
   exp_t me;

   fp_div_arbiter dut (
      .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .o_div_a_operand(div_a), .o_div_b_operand(div_b),
      .o_div_reset_n(div_reset_n), .i_div_result(div_result), .o_rsp_valid(rsp_valid),
      .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_idle(idle)
   );

   always #5 clk = ~clk;

   function automatic logic [P-1:0] div_fn(input logic [P-1:0] a, input logic [P-1:0] b);
      if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
      if (a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000;
      return a ^ {b[15:0], b[31:16]};
   endfunction

   // Stand-in divider: result valid DIV_LATENCY cycles after the operands.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pipe[0] <= div_fn(div_a, div_b);
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
   end
   assign div_result = pipe[L-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [P-1:0] a, input logic [P-1:0] b);
      req_a[i*P +: P] = a;
      req_b[i*P +: P] = b;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40 && !(idle && q.size() == 0); i++) @(negedge clk);
      chk(tag, idle, 1'b1);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (|req_ready) begin
            mg = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) mg = i;
            chk("gnt_onehot", $onehot(req_ready), 1'b1);
            chk("gnt_valid", req_valid[mg], 1'b1);
            chk("issue_a", div_a, req_a[mg*P +: P]);
            chk("issue_b", div_b, req_b[mg*P +: P]);
            me.id = 2'(mg);
            me.data = div_fn(req_a[mg*P +: P], req_b[mg*P +: P]);
            me.at = cyc + L + 1;
            q.push_back(me);
         end else begin
            chk("nogrant_op_a", div_a, 0);
            chk("nogrant_op_b", div_b, 0);
         end
         if (|rsp_valid) begin
            chk("rsp_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
               me = q.pop_front();
               chk("rsp_id", rsp_id, me.id);
               chk("rsp_onehot", rsp_valid, 4'b0001 << me.id);
               chk("rsp_data", rsp_data, me.data);
               chk("rsp_cycle", cyc, me.at);
            end
         end else if (q.size() > 0 && q[0].at <= cyc) begin
            chk("rsp_missing", rsp_valid, 4'b0001 << q[0].id);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_idle", idle, 1'b1);
      chk("rst_ready", req_ready, 0);
      chk("rst_div_reset_n", div_reset_n, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      tick();
      reset = 1'b0;
      // Single request 6.0/2.0
      set_req(0, 32'h40C00000, 32'h40000000);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("single_gnt", req_ready, 4'b0001);
      chk("single_op_a", div_a, 32'h40C00000);
      chk("single_div_reset_n", div_reset_n, 1'b1);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("single_gnt_once", req_ready, 0);
      repeat (5) @(negedge clk);
      chk("single_rsp_valid", rsp_valid, 4'b0001);
      chk("single_rsp_id", rsp_id, 0);
      chk("single_rsp_data", rsp_data, 32'h40400000);
      chk("single_busy", idle, 1'b0);
      @(negedge clk);
      chk("single_idle", idle, 1'b1);
      chk("single_rsp_clr", rsp_valid, 0);
      // Routing: requester 2 then requester 1
      tick();
      set_req(2, 32'h3F800000, 32'h40000000);
      set_req(1, 32'h40C00000, 32'h40000000);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("route_gnt2", req_ready, 4'b0100);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("route_gnt1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      repeat (5) @(negedge clk);
      chk("route_id2", rsp_id, 2);
      chk("route_data2", rsp_data, 32'h3F000000);
      @(negedge clk);
      chk("route_id1", rsp_id, 1);
      chk("route_data1", rsp_data, 32'h40400000);
      wait_idle("route_idle");
      // Credit limit on requester 3
      tick();
      set_req(3, 32'h41200000, 32'h40A00000);
      req_valid = 4'b1000;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("credit_gnt%0d", c), req_ready, (c < 3 || c == 7) ? 4'b1000 : 4'b0000);
         if (c == 6) chk("credit_rsp", rsp_valid, 4'b1000);
      end
      tick();
      req_valid = '0;
      wait_idle("credit_idle");
      // Idle slots on requester 1
      tick();
      set_req(1, 32'h40800000, 32'h3F800000);
      for (int c = 0; c < 6; c++) begin
         req_valid = (c % 2 == 0) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         chk($sformatf("slot_gnt%0d", c), req_ready, (c % 2 == 0) ? 4'b0010 : 4'b0000);
         chk($sformatf("slot_op_a%0d", c), div_a, (c % 2 == 0) ? 32'h40800000 : 32'h0);
         tick();
      end
      req_valid = '0;
      wait_idle("slot_idle");
      // Reset while four divisions are in flight
      tick();
      for (int i = 0; i < N; i++) set_req(i, 32'h3F800000 + 32'(i), 32'h40000000 - 32'(i));
      req_valid = 4'hF;
      repeat (4) tick();
      req_valid = '0;
      repeat (2) tick();
      reset = 1'b1;
      req_valid = 4'hF;
      q.delete();
      @(negedge clk);
      chk("mid_div_reset_n", div_reset_n, 1'b0);
      chk("mid_ready", req_ready, 0);
      chk("mid_idle", idle, 1'b1);
      chk("mid_rsp_valid", rsp_valid, 0);
      tick();
      reset = 1'b0;
      // Fairness from rr_ptr 0 with all requesters active
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("fair_gnt%0d", c), req_ready, 4'b0001 << (c % 4));
      end
      tick();
      req_valid = '0;
      wait_idle("final_idle");
      chk("final_queue", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
